// File: rtl/keypad_if.sv
// Keypad scanner signal bundle: matrix lines toward the keypad,
// debounced key code toward the decoder stage.
interface keypad_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] onehot;
    logic        key_valid;
    logic        key_pulse;
    logic        multi;

    modport master (
        input  row,
        output col, onehot, key_valid, key_pulse, multi
    );

    modport slave (
        output row,
        input  col, onehot, key_valid, key_pulse, multi
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with frame-level debounce.
// Presents the committed key as a one-hot code; >1 key flags multi.
module keypad_scan #(
    parameter int SCAN_DIV        = 1250,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic     clk,
    input  logic     rst,
    keypad_if.master kp
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] CNT_MAX   = DW'(DEBOUNCE_FRAMES);

    logic [SW-1:0] slot;
    logic [1:0]    col_idx;
    logic [3:0]    row_s1;
    logic [3:0]    row_s2;
    logic [15:0]   frame;
    logic [15:0]   prev;
    logic [DW-1:0] stable_cnt;

    logic          slot_end;
    logic          frame_end;
    logic [3:0]    pressed;
    logic [15:0]   cur;
    logic [DW-1:0] cnt_next;
    logic          commit;
    logic          is_single;
    logic          is_multi;
    logic [15:0]   new_oh;

    assign slot_end  = (slot == SLOT_LAST);
    assign frame_end = slot_end && (col_idx == 2'd3);
    assign pressed   = ~row_s2;
    assign cur       = {pressed, frame[11:0]};

    // Column drive released entirely while held in reset
    assign kp.col = rst ? 4'b1111 : ~(4'b0001 << col_idx);

    // Frame-end debounce compare and classification of the snapshot
    always_comb begin
        cnt_next  = stable_cnt;
        commit    = 1'b0;
        if (cur == prev) begin
            if (stable_cnt != CNT_MAX) begin
                cnt_next = stable_cnt + 1'b1;
                commit   = (cnt_next == CNT_MAX);
            end
        end else begin
            cnt_next = '0;
        end
        is_single = (cur != 16'h0) && ((cur & (cur - 16'h1)) == 16'h0);
        is_multi  = (cur != 16'h0) && !is_single;
        new_oh    = is_single ? cur : 16'h0;
    end

    // Slot/column sequencing and 2-flop row synchronizer
    always_ff @(posedge clk) begin
        if (rst) begin
            slot    <= '0;
            col_idx <= 2'd0;
            row_s1  <= 4'b1111;
            row_s2  <= 4'b1111;
        end else begin
            row_s1 <= kp.row;
            row_s2 <= row_s1;
            if (slot_end) begin
                slot    <= '0;
                col_idx <= col_idx + 2'd1;
            end else begin
                slot <= slot + 1'b1;
            end
        end
    end

    // Snapshot capture and stability counting across frames
    always_ff @(posedge clk) begin
        if (rst) begin
            frame      <= 16'h0;
            prev       <= 16'h0;
            stable_cnt <= '0;
        end else begin
            if (slot_end)
                frame[{col_idx, 2'b00} +: 4] <= pressed;
            if (frame_end) begin
                prev       <= cur;
                stable_cnt <= cnt_next;
            end
        end
    end

    // Registered outputs; change only on a committing frame end
    always_ff @(posedge clk) begin
        if (rst) begin
            kp.onehot    <= 16'h0;
            kp.key_valid <= 1'b0;
            kp.key_pulse <= 1'b0;
            kp.multi     <= 1'b0;
        end else begin
            kp.key_pulse <= 1'b0;
            if (frame_end && commit) begin
                kp.onehot    <= new_oh;
                kp.key_valid <= (new_oh != 16'h0);
                kp.multi     <= is_multi;
                kp.key_pulse <= (new_oh != 16'h0) && (new_oh != kp.onehot);
            end
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// Randomized and directed bench for keypad_scan with a frame-level
// reference model built from per-cycle keypad history.
module tb_keypad_scan;
    localparam int SD = 4;
    localparam int DF = 3;
    localparam int FR = 4 * SD;
    localparam int LAT = (DF + 2) * FR + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] keys = 16'h0;
    logic [3:0]  row_drv;

    keypad_if kif ();

    keypad_scan #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_FRAMES (DF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif.master)
    );

    always #5 clk = ~clk;

    // Matrix model: row r pulled low when its column is driven and key held
    always_comb begin
        row_drv = 4'b1111;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!kif.col[c] && keys[4*c+r])
                    row_drv[r] = 1'b0;
    end
    assign kif.row = row_drv;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int t        = 0;

    logic [15:0] hist  [$];
    logic [15:0] snaps [$];
    logic [15:0] m_onehot;
    logic        m_valid;
    logic        m_pulse;
    logic        m_multi;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    task automatic model_clear();
        t = 0;
        hist.delete();
        snaps.delete();
        snaps.push_back(16'h0);
        m_onehot = 16'h0;
        m_valid  = 1'b0;
        m_pulse  = 1'b0;
        m_multi  = 1'b0;
    endtask

    // One clock: check column, advance model, compare registered outputs
    task automatic step();
        logic [3:0]  ecol;
        logic [15:0] cur;
        logic [15:0] h;
        logic [15:0] noh;
        int          f;
        int          run;
        ecol = ~(4'b0001 << ((t / SD) % 4));
        chk("col", 32'(kif.col), 32'(ecol));
        hist.push_back(keys);
        m_pulse = 1'b0;
        if (t % FR == FR - 1) begin
            f   = t / FR;
            cur = 16'h0;
            for (int c = 0; c < 4; c++) begin
                h = hist[f*FR + c*SD + 1];
                for (int r = 0; r < 4; r++)
                    cur[4*c+r] = h[4*c+r];
            end
            snaps.push_back(cur);
            run = 0;
            for (int i = snaps.size() - 1; i >= 0; i--) begin
                if (snaps[i] != cur) break;
                run++;
            end
            if (run == DF + 1) begin
                noh      = ($countones(cur) == 1) ? cur : 16'h0;
                m_pulse  = (noh != 16'h0) && (noh != m_onehot);
                m_onehot = noh;
                m_valid  = (noh != 16'h0);
                m_multi  = ($countones(cur) >= 2);
            end
        end
        @(posedge clk);
        #1;
        t++;
        if (kif.key_pulse) pulses++;
        chk("onehot", 32'(kif.onehot), 32'(m_onehot));
        chk("key_valid", 32'(kif.key_valid), 32'(m_valid));
        chk("key_pulse", 32'(kif.key_pulse), 32'(m_pulse));
        chk("multi", 32'(kif.multi), 32'(m_multi));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_col", 32'(kif.col), 32'h0000_000f);
        chk("rst_onehot", 32'(kif.onehot), 32'h0);
        chk("rst_valid", 32'(kif.key_valid), 32'h0);
        chk("rst_pulse", 32'(kif.key_pulse), 32'h0);
        chk("rst_multi", 32'(kif.multi), 32'h0);
        rst = 1'b0;
        #1;
        chk("rel_col", 32'(kif.col), 32'h0000_000e);
        model_clear();
    endtask

    initial begin
        logic [15:0] pat;
        int          kind;
        #2;
        do_reset();
        steps(3 * FR + $urandom_range(0, FR - 1));

        // Single key (row1,col2) at a random phase
        pulses = 0;
        keys = 16'h0200;
        steps(LAT);
        chk("press_onehot", 32'(kif.onehot), 32'h0200);
        chk("press_valid", 32'(kif.key_valid), 32'h1);
        chk("press_pulses", 32'(pulses), 32'h1);

        // Long hold, then release
        steps(20 * FR);
        chk("hold_onehot", 32'(kif.onehot), 32'h0200);
        chk("hold_pulses", 32'(pulses), 32'h1);
        keys = 16'h0;
        steps(LAT);
        chk("rel_onehot", 32'(kif.onehot), 32'h0);
        chk("rel_valid", 32'(kif.key_valid), 32'h0);
        chk("rel_pulses", 32'(pulses), 32'h1);

        // Bounce on (row0,col0) every frame, then settle
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 0) ? 16'h0001 : 16'h0000;
            steps(FR);
        end
        chk("bounce_onehot", 32'(kif.onehot), 32'h0);
        chk("bounce_pulses", 32'(pulses), 32'h0);
        keys = 16'h0001;
        steps(LAT);
        chk("settle_onehot", 32'(kif.onehot), 32'h0001);
        chk("settle_pulses", 32'(pulses), 32'h1);

        // Two keys (row0,col2)+(row3,col1), then release one
        pulses = 0;
        keys = 16'h0180;
        steps(LAT);
        chk("multi_flag", 32'(kif.multi), 32'h1);
        chk("multi_onehot", 32'(kif.onehot), 32'h0);
        chk("multi_valid", 32'(kif.key_valid), 32'h0);
        chk("multi_pulses", 32'(pulses), 32'h0);
        keys = 16'h0100;
        steps(LAT);
        chk("one_left_multi", 32'(kif.multi), 32'h0);
        chk("one_left_onehot", 32'(kif.onehot), 32'h0100);

        // Reset mid-frame while a key is committed
        keys = 16'h0200;
        steps(LAT);
        chk("pre_rst_onehot", 32'(kif.onehot), 32'h0200);
        steps($urandom_range(1, FR - 2));
        do_reset();
        pulses = 0;
        steps(LAT);
        chk("post_rst_onehot", 32'(kif.onehot), 32'h0200);
        chk("post_rst_pulses", 32'(pulses), 32'h1);

        // Random key patterns at random phases and durations
        for (int seg = 0; seg < 60; seg++) begin
            kind = $urandom_range(0, 4);
            pat  = 16'h0;
            if (kind == 1 || kind == 2)
                pat = 16'h1 << $urandom_range(0, 15);
            else if (kind == 3)
                pat = (16'h1 << $urandom_range(0, 15))
                    | (16'h1 << $urandom_range(0, 15));
            else if (kind == 4)
                pat = 16'($urandom());
            keys = pat;
            if ($urandom_range(0, 3) == 0)
                steps($urandom_range(1, 2 * FR));
            else
                steps($urandom_range(FR, 7 * FR));
            if ($urandom_range(0, 19) == 0) begin
                do_reset();
                steps($urandom_range(0, FR));
            end
        end

        keys = 16'h0;
        steps(LAT);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
